// File: rtl/trading_strategy_engine_pkg.sv
// Shared types for the trading strategy engine: message codes, decision record, helpers.
package trading_pkg;

  localparam logic [7:0] MSG_TRADE = 8'h50;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef struct packed {
    side_e       side;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } decision_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trading_strategy_engine_if.sv
// Message-in and decision-out buses of the trading strategy engine.
interface trading_strategy_engine_if;

  logic        field_valid;
  logic [7:0]  msg_type;
  logic [63:0] order_id;
  logic [31:0] price;
  logic [31:0] volume;
  logic        in_ready;

  logic        decision_valid;
  logic        decision_ready;
  logic        decision_side;
  logic [63:0] d_order_id;
  logic [31:0] d_price;
  logic [31:0] d_volume;

  // Message side: a beat transfers on field_valid && in_ready; beats offered while in_ready
  // is low are lost (no upstream stall). Decision side: the head transfers on
  // decision_valid && decision_ready, and d_* stay stable while valid is held without ready.
  modport master (
    output field_valid, msg_type, order_id, price, volume, decision_ready,
    input  in_ready, decision_valid, decision_side, d_order_id, d_price, d_volume
  );

  modport slave (
    input  field_valid, msg_type, order_id, price, volume, decision_ready,
    output in_ready, decision_valid, decision_side, d_order_id, d_price, d_volume
  );

endinterface

// File: rtl/trading_strategy_engine_fifo.sv
// Show-ahead synchronous FIFO holding issued decisions; DEPTH must be a power of two.
module decision_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_ONE;
  end

  // Storage is cleared on reset so the echoed fields read zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trading_strategy_engine.sv
// Threshold trading strategy on 'P' trade messages, gated by a net-position limit and a
// token-bucket rate limiter; issued decisions queue in a show-ahead FIFO.
module trading_strategy_engine
  import trading_pkg::*;
#(
  parameter int  POS_LIMIT     = 1_000_000,
  parameter int  POS_W         = 40,
  parameter int  BURST         = 8,
  parameter int  REFILL_CYCLES = 1000,
  parameter int  FIFO_DEPTH    = 4,
  localparam int TOK_W         = $clog2(BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  trading_strategy_engine_if.slave bus,
  input  logic                     strategy_en,
  input  logic [31:0]              cfg_buy_thresh,
  input  logic [31:0]              cfg_sell_thresh,
  output logic signed [POS_W-1:0]  net_position,
  output logic [31:0]              reject_pos_cnt,
  output logic [31:0]              reject_rate_cnt,
  output logic [TOK_W-1:0]         dbg_tokens
);

  localparam int RC_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [RC_W-1:0]         RC_LAST  = RC_W'(REFILL_CYCLES - 1);
  localparam logic [TOK_W-1:0]        TOK_FULL = TOK_W'(BURST);
  localparam logic signed [POS_W-1:0] POS_MAX  = POS_W'(POS_LIMIT);
  localparam logic signed [POS_W-1:0] POS_MIN  = -POS_MAX;

  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] vol_s, buy_pos, sell_pos;
  logic [TOK_W-1:0]        tokens_q, tokens_d;
  logic [RC_W-1:0]         refill_q, refill_d;
  logic [31:0]             rej_pos_q, rej_pos_d;
  logic [31:0]             rej_rate_q, rej_rate_d;
  logic accept, is_trade, want_buy, want_sell, candidate;
  logic pos_ok, rate_ok, issue, refill_tick;
  logic fifo_full, fifo_empty;
  decision_t push_data, head;

  assign accept    = bus.field_valid && bus.in_ready;
  assign is_trade  = accept && strategy_en && (bus.msg_type == MSG_TRADE);
  assign want_buy  = is_trade && (bus.price < cfg_buy_thresh);
  assign want_sell = is_trade && !want_buy && (bus.price > cfg_sell_thresh);
  assign candidate = want_buy || want_sell;

  // Volume is zero-extended so the signed position sums cannot overflow for legal POS_W.
  assign vol_s    = $signed({{(POS_W - 32){1'b0}}, bus.volume});
  assign buy_pos  = pos_q + vol_s;
  assign sell_pos = pos_q - vol_s;
  assign pos_ok   = want_buy ? (buy_pos <= POS_MAX) : (sell_pos >= POS_MIN);
  assign rate_ok  = (tokens_q != '0);
  assign issue    = candidate && pos_ok && rate_ok;

  assign refill_tick = (refill_q == RC_LAST);

  always_comb begin
    refill_d = refill_tick ? '0 : refill_q + RC_W'(1);
    tokens_d = tokens_q;
    if (issue && !refill_tick) tokens_d = tokens_q - TOK_W'(1);
    else if (!issue && refill_tick && (tokens_q != TOK_FULL)) tokens_d = tokens_q + TOK_W'(1);
    pos_d = pos_q;
    if (issue) pos_d = want_buy ? buy_pos : sell_pos;
    // A position reject short-circuits the rate check, so only one counter moves per message.
    rej_pos_d  = (candidate && !pos_ok) ? sat_inc(rej_pos_q) : rej_pos_q;
    rej_rate_d = (candidate && pos_ok && !rate_ok) ? sat_inc(rej_rate_q) : rej_rate_q;
  end

  always_comb begin
    push_data.side     = want_buy ? SIDE_BUY : SIDE_SELL;
    push_data.order_id = bus.order_id;
    push_data.price    = bus.price;
    push_data.volume   = bus.volume;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= '0;
      tokens_q   <= TOK_FULL;
      refill_q   <= '0;
      rej_pos_q  <= '0;
      rej_rate_q <= '0;
    end else begin
      pos_q      <= pos_d;
      tokens_q   <= tokens_d;
      refill_q   <= refill_d;
      rej_pos_q  <= rej_pos_d;
      rej_rate_q <= rej_rate_d;
    end
  end

  decision_fifo #(
    .T     (decision_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue),
    .data_i  (push_data),
    .pop_i   (bus.decision_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready       = !fifo_full;
  assign bus.decision_valid = !fifo_empty;
  assign bus.decision_side  = head.side;
  assign bus.d_order_id     = head.order_id;
  assign bus.d_price        = head.price;
  assign bus.d_volume       = head.volume;

  assign net_position    = pos_q;
  assign reject_pos_cnt  = rej_pos_q;
  assign reject_rate_cnt = rej_rate_q;
  assign dbg_tokens      = tokens_q;

endmodule
